// File: rtl/stream_pixel_packer_if.sv
// Pixel-in / packed-word-out bundle for stream_pixel_packer.
// The master modport is the packer's view and the slave modport is the surrounding pipeline's view.
interface stream_pixel_packer_if #(
    parameter int COLOR_WIDTH = 8
);
    logic [COLOR_WIDTH-1:0] r;
    logic [COLOR_WIDTH-1:0] g;
    logic [COLOR_WIDTH-1:0] b;
    logic                   valid;
    logic                   sof;
    logic                   eol;
    logic                   in_stream_ready;
    logic [31:0]            out_stream_tdata;
    logic [3:0]             out_stream_tkeep;
    logic                   out_stream_tlast;
    logic                   out_stream_tuser;
    logic                   out_stream_tvalid;
    logic                   out_stream_tready;
    logic                   line_err;

    modport master (
        input  r, g, b, valid, sof, eol, out_stream_tready,
        output in_stream_ready, out_stream_tdata, out_stream_tkeep,
               out_stream_tlast, out_stream_tuser, out_stream_tvalid, line_err
    );

    modport slave (
        output r, g, b, valid, sof, eol, out_stream_tready,
        input  in_stream_ready, out_stream_tdata, out_stream_tkeep,
               out_stream_tlast, out_stream_tuser, out_stream_tvalid, line_err
    );
endinterface

// File: rtl/stream_pixel_packer.sv
// Packs 24-bit {r,g,b} pixels into a dense 32-bit stream (4 pixels -> 3 words).
// The output goes through a 3-entry first-word-fall-through FIFO.
module stream_pixel_packer #(
    parameter int COLOR_WIDTH = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    stream_pixel_packer_if.master bus
);
    localparam int PIXEL_W = 3 * COLOR_WIDTH;

    typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        user;
    } word_t;

    phase_t             phase_reg, phase_next, eff_phase;
    logic [23:0]        resid_reg, resid_next;
    logic               pend_reg, pend_next;
    logic               line_err_reg, line_err_next;
    logic [PIXEL_W-1:0] pixel;
    word_t              word_a, word_b, head;
    logic               push_a, push_b, pop, accept, ready_int;
    logic [1:0]         wr_ptr_reg, rd_ptr_reg, count_reg, wr_ptr_b;
    word_t              entry_q [3];

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign pixel     = {bus.r, bus.g, bus.b};
    // Two free slots guarantee that one accepted pixel can always push two words.
    assign ready_int = aresetn && (count_reg <= 2'd1);
    assign accept    = bus.valid && ready_int;

    always_comb begin
        phase_next    = phase_reg;
        resid_next    = resid_reg;
        pend_next     = pend_reg;
        line_err_next = 1'b0;
        push_a        = 1'b0;
        push_b        = 1'b0;
        word_a        = '0;
        word_b        = '0;
        // A start-of-frame pixel always restarts the group, dropping any residual.
        eff_phase     = bus.sof ? PH0 : phase_reg;
        if (accept) begin
            line_err_next = (bus.sof && (phase_reg != PH0)) || (bus.eol && (eff_phase != PH3));
            case (eff_phase)
                PH0: begin
                    resid_next = pixel[23:0];
                    pend_next  = bus.sof;
                    phase_next = PH1;
                    if (bus.eol) begin
                        push_a      = 1'b1;
                        word_a.data = {8'h00, pixel[23:0]};
                        word_a.last = 1'b1;
                        word_a.user = bus.sof;
                    end
                end
                PH1: begin
                    push_a      = 1'b1;
                    word_a.data = {pixel[7:0], resid_reg};
                    word_a.user = pend_reg;
                    pend_next   = 1'b0;
                    resid_next  = {8'h00, pixel[23:8]};
                    phase_next  = PH2;
                    if (bus.eol) begin
                        push_b      = 1'b1;
                        word_b.data = {16'h0000, pixel[23:8]};
                        word_b.last = 1'b1;
                    end
                end
                PH2: begin
                    push_a      = 1'b1;
                    word_a.data = {pixel[15:0], resid_reg[15:0]};
                    resid_next  = {16'h0000, pixel[23:16]};
                    phase_next  = PH3;
                    if (bus.eol) begin
                        push_b      = 1'b1;
                        word_b.data = {24'h000000, pixel[23:16]};
                        word_b.last = 1'b1;
                    end
                end
                default: begin
                    push_a      = 1'b1;
                    word_a.data = {pixel[23:0], resid_reg[7:0]};
                    word_a.last = bus.eol;
                    resid_next  = '0;
                    phase_next  = PH0;
                end
            endcase
            if (bus.eol) begin
                phase_next = PH0;
                resid_next = '0;
                pend_next  = 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase_reg    <= PH0;
            resid_reg    <= '0;
            pend_reg     <= 1'b0;
            line_err_reg <= 1'b0;
        end else begin
            phase_reg    <= phase_next;
            resid_reg    <= resid_next;
            pend_reg     <= pend_next;
            line_err_reg <= line_err_next;
        end
    end

    assign pop      = (count_reg != 2'd0) && bus.out_stream_tready;
    assign wr_ptr_b = next_ptr(wr_ptr_reg);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_b) begin
                wr_ptr_reg <= next_ptr(wr_ptr_b);
            end else if (push_a) begin
                wr_ptr_reg <= wr_ptr_b;
            end
            if (pop) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            count_reg <= count_reg + {1'b0, push_a} + {1'b0, push_b} - {1'b0, pop};
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_entry
        word_t entry_reg;
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                entry_reg <= '0;
            end else if (push_a && (wr_ptr_reg == 2'(gi))) begin
                entry_reg <= word_a;
            end else if (push_b && (wr_ptr_b == 2'(gi))) begin
                entry_reg <= word_b;
            end
        end
        assign entry_q[gi] = entry_reg;
    end

    assign head                  = entry_q[rd_ptr_reg];
    assign bus.in_stream_ready   = ready_int;
    assign bus.out_stream_tdata  = head.data;
    assign bus.out_stream_tlast  = head.last;
    assign bus.out_stream_tuser  = head.user;
    assign bus.out_stream_tvalid = (count_reg != 2'd0);
    assign bus.out_stream_tkeep  = 4'hF;
    assign bus.line_err          = line_err_reg;
endmodule

// File: tb/tb_stream_pixel_packer.sv
// Directed bench for stream_pixel_packer: vector table plus hand-written
// backpressure, full-rate and mid-stream reset sequences.
module tb_stream_pixel_packer;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    stream_pixel_packer_if #(.COLOR_WIDTH(8)) sif();

    stream_pixel_packer #(.COLOR_WIDTH(8)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (sif.master)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic        u;
    } word_t;

    typedef struct {
        logic [23:0] pix;
        logic        sof;
        logic        eol;
        logic        err;
        int          nw;
        word_t       w0;
        word_t       w1;
    } vec_t;

    word_t obs_q[$];
    word_t exp_q[$];
    vec_t  vt[18];
    int    cmp_count = 0;
    int    fail_count = 0;
    bit    quiet = 1'b0;
    bit    monitor_stall = 1'b0;
    int    stall_seen = 0;
    bit    prev_hold = 1'b0;
    word_t prev_word;

    function automatic word_t w(input logic [31:0] d, input logic l, input logic u);
        word_t x;
        x.d = d;
        x.l = l;
        x.u = u;
        return x;
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else if (!quiet) begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Output collector and hold-stability monitor, sampled mid-cycle.
    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_stable", {5'd0, sif.out_stream_tvalid, sif.out_stream_tdata, sif.out_stream_tlast, sif.out_stream_tuser},
                    {5'd0, 1'b1, prev_word});
            end
            if (sif.out_stream_tvalid && sif.out_stream_tready) begin
                obs_q.push_back(w(sif.out_stream_tdata, sif.out_stream_tlast, sif.out_stream_tuser));
            end
            if (monitor_stall && sif.valid && !sif.in_stream_ready) stall_seen++;
            prev_hold = sif.out_stream_tvalid && !sif.out_stream_tready;
            prev_word = w(sif.out_stream_tdata, sif.out_stream_tlast, sif.out_stream_tuser);
        end
    end

    task automatic send(input logic [23:0] p, input logic s, input logic e);
        int guard;
        guard = 0;
        sif.r = p[23:16];
        sif.g = p[15:8];
        sif.b = p[7:0];
        sif.sof = s;
        sif.eol = e;
        sif.valid = 1'b1;
        while (!sif.in_stream_ready && guard < 100) begin
            @(posedge aclk);
            #1;
            guard++;
        end
        if (guard >= 100) chk("ready_timeout", 40'd0, 40'd1);
        @(posedge aclk);
        #1;
        sif.valid = 1'b0;
        sif.sof = 1'b0;
        sif.eol = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sif.out_stream_tvalid && guard < 60) begin
            @(posedge aclk);
            #1;
            guard++;
        end
        if (guard >= 60) chk("drain_timeout", 40'd0, 40'd1);
    endtask

    task automatic cmp_words(input string tag);
        chk({tag, "_count"}, 40'(obs_q.size()), 40'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("%s_w%0d", tag, i), 40'(obs_q[i]), 40'(exp_q[i]));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] px;
        int k;
        sif.r = '0; sif.g = '0; sif.b = '0;
        sif.valid = 1'b0; sif.sof = 1'b0; sif.eol = 1'b0;
        sif.out_stream_tready = 1'b0;

        vt[0]  = '{24'h112233, 1'b1, 1'b0, 1'b0, 0, '0, '0};
        vt[1]  = '{24'h445566, 1'b0, 1'b0, 1'b0, 1, w(32'h66112233, 1'b0, 1'b1), '0};
        vt[2]  = '{24'h778899, 1'b0, 1'b0, 1'b0, 1, w(32'h88994455, 1'b0, 1'b0), '0};
        vt[3]  = '{24'hAABBCC, 1'b0, 1'b1, 1'b0, 1, w(32'hAABBCC77, 1'b1, 1'b0), '0};
        vt[4]  = '{24'h112233, 1'b0, 1'b0, 1'b0, 0, '0, '0};
        vt[5]  = '{24'h445566, 1'b0, 1'b1, 1'b1, 2, w(32'h66112233, 1'b0, 1'b0), w(32'h00004455, 1'b1, 1'b0)};
        vt[6]  = '{24'h010203, 1'b0, 1'b1, 1'b1, 1, w(32'h00010203, 1'b1, 1'b0), '0};
        vt[7]  = '{24'hA1A2A3, 1'b0, 1'b0, 1'b0, 0, '0, '0};
        vt[8]  = '{24'hB1B2B3, 1'b0, 1'b0, 1'b0, 1, w(32'hB3A1A2A3, 1'b0, 1'b0), '0};
        vt[9]  = '{24'hC1C2C3, 1'b0, 1'b1, 1'b1, 2, w(32'hC2C3B1B2, 1'b0, 1'b0), w(32'h000000C1, 1'b1, 1'b0)};
        vt[10] = '{24'h102030, 1'b0, 1'b0, 1'b0, 0, '0, '0};
        vt[11] = '{24'h405060, 1'b0, 1'b0, 1'b0, 1, w(32'h60102030, 1'b0, 1'b0), '0};
        vt[12] = '{24'h708090, 1'b1, 1'b0, 1'b1, 0, '0, '0};
        vt[13] = '{24'hA0B0C0, 1'b0, 1'b0, 1'b0, 1, w(32'hC0708090, 1'b0, 1'b1), '0};
        vt[14] = '{24'hD0E0F0, 1'b0, 1'b0, 1'b0, 1, w(32'hE0F0A0B0, 1'b0, 1'b0), '0};
        vt[15] = '{24'h123456, 1'b0, 1'b1, 1'b0, 1, w(32'h123456D0, 1'b1, 1'b0), '0};
        vt[16] = '{24'h111111, 1'b0, 1'b0, 1'b0, 0, '0, '0};
        vt[17] = '{24'h222222, 1'b1, 1'b1, 1'b1, 1, w(32'h00222222, 1'b1, 1'b1), '0};

        // Reset state
        #12;
        chk("rst_ready", 40'(sif.in_stream_ready), 40'd0);
        chk("rst_tvalid", 40'(sif.out_stream_tvalid), 40'd0);
        chk("rst_tdata", 40'(sif.out_stream_tdata), 40'd0);
        chk("rst_tlast_tuser", 40'({sif.out_stream_tlast, sif.out_stream_tuser}), 40'd0);
        chk("rst_line_err", 40'(sif.line_err), 40'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("ready_after_rst", 40'(sif.in_stream_ready), 40'd1);
        chk("tkeep", 40'(sif.out_stream_tkeep), 40'hF);
        @(posedge aclk);
        #1;

        // Vector table at full output rate
        sif.out_stream_tready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            send(vt[i].pix, vt[i].sof, vt[i].eol);
            chk($sformatf("vec%0d_line_err", i), 40'(sif.line_err), 40'(vt[i].err));
            if (i == 1) chk("latency_tvalid", 40'(sif.out_stream_tvalid), 40'd1);
            if (vt[i].nw > 0) exp_q.push_back(vt[i].w0);
            if (vt[i].nw > 1) exp_q.push_back(vt[i].w1);
        end
        drain();
        cmp_words("table");

        // Backpressure: stream bytes are 00,01,02,... so words read as consecutive bytes
        sif.out_stream_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            px = {8'(3 * i + 2), 8'(3 * i + 1), 8'(3 * i)};
            send(px, i == 0, 1'b0);
            if (i == 1) begin
                chk("bp_latency", 40'({sif.out_stream_tvalid, sif.out_stream_tdata}), 40'({1'b1, 32'h03020100}));
                chk("bp_ready_occ1", 40'(sif.in_stream_ready), 40'd1);
            end
        end
        chk("bp_ready_occ2", 40'(sif.in_stream_ready), 40'd0);
        px = {8'd11, 8'd10, 8'd9};
        fork
            send(px, 1'b0, 1'b0);
            begin
                repeat (3) @(posedge aclk);
                #1;
                sif.out_stream_tready = 1'b1;
            end
        join
        for (int i = 4; i < 8; i++) begin
            px = {8'(3 * i + 2), 8'(3 * i + 1), 8'(3 * i)};
            send(px, 1'b0, i == 7);
        end
        drain();
        exp_q.push_back(w(32'h03020100, 1'b0, 1'b1));
        exp_q.push_back(w(32'h07060504, 1'b0, 1'b0));
        exp_q.push_back(w(32'h0B0A0908, 1'b0, 1'b0));
        exp_q.push_back(w(32'h0F0E0D0C, 1'b0, 1'b0));
        exp_q.push_back(w(32'h13121110, 1'b0, 1'b0));
        exp_q.push_back(w(32'h17161514, 1'b1, 1'b0));
        cmp_words("backpressure");

        // Full-rate: two lines of 640 pixels
        quiet = 1'b1;
        monitor_stall = 1'b1;
        stall_seen = 0;
        for (int ln = 0; ln < 2; ln++) begin
            for (int i = 0; i < 640; i++) begin
                k = ln * 640 + i;
                px = {8'(3 * k + 2), 8'(3 * k + 1), 8'(3 * k)};
                send(px, k == 0, i == 639);
            end
        end
        monitor_stall = 1'b0;
        drain();
        for (int j = 0; j < 960; j++) begin
            exp_q.push_back(w({8'(4 * j + 3), 8'(4 * j + 2), 8'(4 * j + 1), 8'(4 * j)}, (j % 480) == 479, j == 0));
        end
        $display("full-rate: %0d words observed", obs_q.size());
        cmp_words("fullrate");
        quiet = 1'b0;
        chk("fullrate_no_stall", 40'(stall_seen), 40'd0);

        // Reset with two words buffered
        sif.out_stream_tready = 1'b0;
        send(24'h0A0B0C, 1'b1, 1'b0);
        send(24'h0D0E0F, 1'b0, 1'b0);
        send(24'h101112, 1'b0, 1'b0);
        chk("pre_rst_tvalid", 40'(sif.out_stream_tvalid), 40'd1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", 40'(sif.out_stream_tvalid), 40'd0);
        chk("mid_rst_tdata", 40'(sif.out_stream_tdata), 40'd0);
        chk("mid_rst_ready", 40'(sif.in_stream_ready), 40'd0);
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        sif.out_stream_tready = 1'b1;
        obs_q.delete();
        repeat (5) @(posedge aclk);
        #1;
        chk("post_rst_no_stale", 40'(obs_q.size()), 40'd0);
        send(24'h112233, 1'b1, 1'b0);
        send(24'h445566, 1'b0, 1'b0);
        send(24'h778899, 1'b0, 1'b0);
        send(24'hAABBCC, 1'b0, 1'b1);
        drain();
        exp_q.push_back(w(32'h66112233, 1'b0, 1'b1));
        exp_q.push_back(w(32'h88994455, 1'b0, 1'b0));
        exp_q.push_back(w(32'hAABBCC77, 1'b1, 1'b0));
        cmp_words("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end
endmodule
